// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default inter-stage widths and control bit positions.
package pipe_pkg;

    // Default widths for an inter-stage register
    localparam int DEF_CTRL_W = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NDATA  = 2;
    localparam int DEF_TAG_W  = 5;

    // Bit positions inside the control field
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: a valid bit plus a payload register.
// The payload only changes on a load, so bubbles never toggle the data path.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);

    // Slot register: reset beats clear, clear beats load
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (clear) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= 1'b1;
            q   <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, a two-entry skid
// buffer (output slot + skid slot), flush, legacy stall and bubble-gated control.
// ready_o comes straight from the skid valid flop, so there is no combinational
// path from ready_i or stall_i to ready_o.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NDATA  = DEF_NDATA,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [CTRL_W-1:0]       ctrl_i,
    input  logic [NDATA*DATA_W-1:0] data_i,
    input  logic [TAG_W-1:0]        tag_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [CTRL_W-1:0]       ctrl_o,
    output logic [NDATA*DATA_W-1:0] data_o,
    output logic [TAG_W-1:0]        tag_o
);

    // Payload layout: {ctrl, data words, tag}
    localparam int PW = CTRL_W + NDATA*DATA_W + TAG_W;

    logic          skid_vld_p0;
    logic [PW-1:0] skid_pay_p0;
    logic          out_vld_p1;
    logic [PW-1:0] out_pay_p1;

    logic          in_fire;
    logic          out_fire;
    logic          out_free;
    logic [PW-1:0] in_pay;

    logic          out_load;
    logic          out_clr;
    logic [PW-1:0] out_d;
    logic          skid_load;
    logic          skid_clr;

    assign in_pay   = {ctrl_i, data_i, tag_i};
    assign ready_o  = ~skid_vld_p0;
    assign in_fire  = valid_i & ready_o;
    assign out_fire = out_vld_p1 & ready_i & ~stall_i;
    assign out_free = ~out_vld_p1 | out_fire;

    // Steering: flush first, then refill the output slot (skid has priority
    // over new input to keep FIFO order), else park the input in the skid slot
    always_comb begin
        out_load  = 1'b0;
        out_clr   = 1'b0;
        out_d     = in_pay;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush_i) begin
            out_clr  = 1'b1;
            skid_clr = 1'b1;
        end else if (out_free) begin
            if (skid_vld_p0) begin
                out_load = 1'b1;
                out_d    = skid_pay_p0;
                skid_clr = 1'b1;
            end else if (in_fire) begin
                out_load = 1'b1;
            end else begin
                out_clr = 1'b1;
            end
        end else if (in_fire) begin
            skid_load = 1'b1;
        end
    end

    // ---- stage p0: skid slot ----
    pipe_slot #(.W(PW)) u_skid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (skid_load),
        .clear (skid_clr),
        .d     (in_pay),
        .vld   (skid_vld_p0),
        .q     (skid_pay_p0)
    );

    // ---- stage p1: output slot ----
    pipe_slot #(.W(PW)) u_out (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (out_load),
        .clear (out_clr),
        .d     (out_d),
        .vld   (out_vld_p1),
        .q     (out_pay_p1)
    );

    assign valid_o = out_vld_p1;
    assign ctrl_o  = out_vld_p1 ? out_pay_p1[PW-1 -: CTRL_W] : '0;
    assign data_o  = out_pay_p1[TAG_W +: NDATA*DATA_W];
    assign tag_o   = out_pay_p1[TAG_W-1:0];

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with default widths.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  ctrl_i;
    logic [63:0] data_i;
    logic [4:0]  tag_i;
    logic        stall_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [3:0]  ctrl_o;
    logic [63:0] data_o;
    logic [4:0]  tag_o;

    int errors = 0;
    int checks = 0;

    logic [3:0] c_rw_mw;

    pipe_stage_skid dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .ctrl_i  (ctrl_i),
        .data_i  (data_i),
        .tag_i   (tag_i),
        .stall_i (stall_i),
        .flush_i (flush_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .ctrl_o  (ctrl_o),
        .data_o  (data_o),
        .tag_o   (tag_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        c_rw_mw = '0;
        c_rw_mw[CTRL_REGWRITE] = 1'b1;
        c_rw_mw[CTRL_MEMWRITE] = 1'b1;

        rst_i   = 1'b1;
        valid_i = 1'b1;
        ctrl_i  = 4'hF;
        data_i  = 64'h1111_2222_3333_4444;
        tag_i   = 5'd7;
        stall_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b1;

        // Reset held two cycles with a valid input present
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_valid", valid_o, 1'b0);
            chk("rst_ctrl",  ctrl_o, 4'h0);
            chk("rst_data",  data_o, 64'h0);
            chk("rst_tag",   tag_o, 5'd0);
            chk("rst_ready", ready_o, 1'b1);
        end
        rst_i   = 1'b0;
        valid_i = 1'b0;
        step();
        chk("post_rst_valid", valid_o, 1'b0);
        chk("post_rst_ctrl",  ctrl_o, 4'h0);
        chk("post_rst_data",  data_o, 64'h0);
        chk("post_rst_tag",   tag_o, 5'd0);
        chk("post_rst_ready", ready_o, 1'b1);

        // Stream tags 1..4 back to back
        ctrl_i  = 4'b0101;
        valid_i = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tag_i  = 5'(t);
            data_i = {32'h0, 32'(t * 16)};
            step();
            chk("stream_valid", valid_o, 1'b1);
            chk("stream_tag",   tag_o, 5'(t));
            chk("stream_data",  data_o, {32'h0, 32'(t * 16)});
            chk("stream_ctrl",  ctrl_o, 4'b0101);
            chk("stream_ready", ready_o, 1'b1);
        end
        valid_i = 1'b0;
        step();
        chk("stream_drain_valid", valid_o, 1'b0);
        chk("stream_drain_ctrl",  ctrl_o, 4'h0);

        // Skid: tag 1 to output, then back-pressure with tag 2 on input
        valid_i = 1'b1;
        tag_i   = 5'd1;
        step();
        chk("skid_t1", tag_o, 5'd1);
        ready_i = 1'b0;
        tag_i   = 5'd2;
        step();
        chk("skid_hold_tag",   tag_o, 5'd1);
        chk("skid_ready_low",  ready_o, 1'b0);
        tag_i = 5'd3;
        step();
        chk("skid_hold2_tag",  tag_o, 5'd1);
        chk("skid_ready_low2", ready_o, 1'b0);
        ready_i = 1'b1;
        step();
        chk("skid_t2",        tag_o, 5'd2);
        chk("skid_t2_valid",  valid_o, 1'b1);
        chk("skid_ready_up",  ready_o, 1'b1);
        step();
        chk("skid_t3",        tag_o, 5'd3);
        chk("skid_t3_valid",  valid_o, 1'b1);
        valid_i = 1'b0;
        step();
        chk("skid_drain", valid_o, 1'b0);

        // Stall: entry with word0 DEADBEEF held for 3 stalled cycles
        valid_i = 1'b1;
        tag_i   = 5'd5;
        data_i  = 64'hCAFE_F00D_DEAD_BEEF;
        step();
        chk("stall_load", data_o[31:0], 32'hDEAD_BEEF);
        valid_i = 1'b0;
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", valid_o, 1'b1);
            chk("stall_word0", data_o[31:0], 32'hDEAD_BEEF);
            chk("stall_tag",   tag_o, 5'd5);
        end
        stall_i = 1'b0;
        step();
        chk("stall_release", valid_o, 1'b0);

        // Flush with both slots full and tag 9 offered
        ready_i = 1'b0;
        valid_i = 1'b1;
        tag_i   = 5'd6;
        step();
        tag_i = 5'd7;
        step();
        chk("flush_full_valid", valid_o, 1'b1);
        chk("flush_full_ready", ready_o, 1'b0);
        flush_i = 1'b1;
        tag_i   = 5'd9;
        step();
        chk("flush_valid", valid_o, 1'b0);
        chk("flush_ctrl",  ctrl_o, 4'h0);
        chk("flush_ready", ready_o, 1'b1);
        chk("flush_stale_tag", tag_o, 5'd6);
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        chk("flush_no_t9", valid_o, 1'b0);

        // Flush beats an accepted input into an empty stage
        flush_i = 1'b1;
        valid_i = 1'b1;
        tag_i   = 5'd10;
        step();
        chk("flush_drop_valid", valid_o, 1'b0);
        flush_i = 1'b0;
        valid_i = 1'b0;
        step();
        chk("flush_drop_after", valid_o, 1'b0);

        // Bubble gating of control bits
        ctrl_i  = c_rw_mw;
        valid_i = 1'b0;
        tag_i   = 5'd11;
        step();
        chk("bubble_ctrl",  ctrl_o, 4'h0);
        chk("bubble_valid", valid_o, 1'b0);
        valid_i = 1'b1;
        step();
        chk("gated_ctrl",  ctrl_o, 4'b1001);
        chk("gated_valid", valid_o, 1'b1);
        chk("gated_tag",   tag_o, 5'd11);

        // Reset with both slots full
        ready_i = 1'b0;
        tag_i   = 5'd12;
        step();
        chk("prerst_ready", ready_o, 1'b0);
        rst_i   = 1'b1;
        flush_i = 1'b1;
        step();
        chk("midrst_valid", valid_o, 1'b0);
        chk("midrst_ready", ready_o, 1'b1);
        chk("midrst_tag",   tag_o, 5'd0);
        chk("midrst_data",  data_o, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
